// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative HI/LO multiply/divide unit for a MIPS-style pipeline.
//
// Multiplies use radix-2 shift-add and divides use restoring subtract-shift.
// Both run on operand magnitudes for one iteration per cycle, WIDTH cycles
// per operation. The sign is fixed up on the final edge, when HI/LO are written.
//
// Ports:
//   Clk        in   clock, all state changes on the rising edge
//   Rst        in   synchronous active-high reset (overrides everything)
//   Start      in   launch request for the operation on Op
//   Op[2:0]    in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                   110/111 no-op
//   A, B       in   rs / rt operands
//   Flush      in   abort an in-flight operation; blocks a Start in IDLE
//   HiLoRead   in   ID-stage instruction reads HI/LO
//   Busy       out  iterative operation in progress
//   Done       out  one-cycle pulse: HI/LO hold a freshly written value
//   Stall      out  pipeline hold request = Busy & (Start | HiLoRead)
//   HI, LO     out  registered result registers
//   dbg_state  out  current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: Start is a request qualified only by the FSM being in IDLE. A
// Start that arrives while Busy is dropped; the pipeline is kept from
// re-issuing it by Stall. Done is a one-cycle pulse with no back-pressure.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             HiLoRead,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_main;   // negate product / quotient at the end
    logic             neg_rem;    // negate remainder at the end
    // acc_hi: partial product high half / partial remainder
    // acc_lo: multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude

    // Operand decode for a launch in IDLE
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;

    // One iteration of each algorithm
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    // Sign-corrected final result
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        op_signed = ~Op[0];
        a_neg     = op_signed & A[WIDTH-1];
        b_neg     = op_signed & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
        b_zero    = (B == '0);
    end

    always_comb begin
        // Shift-add: add the multiplicand when the multiplier LSB is set,
        // then shift {carry, acc_hi, acc_lo} right by one.
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

        // Restoring divide: bring the next dividend bit into the remainder
        // and keep the subtraction only when it does not go negative.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[WIDTH]) begin
            rem_n = div_diff[WIDTH-1:0];
            quo_n = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = div_shift[WIDTH-1:0];
            quo_n = {acc_lo[WIDTH-2:0], 1'b0};
        end

        iter_hi = is_div ? rem_n : mul_hi_n;
        iter_lo = is_div ? quo_n : mul_lo_n;

        // MIN / -1 needs no special case: the magnitude quotient is 2^(W-1),
        // whose two's-complement negation is itself.
        prod   = {mul_hi_n, mul_lo_n};
        prod_s = neg_main ? -prod : prod;
        quo_s  = neg_main ? -quo_n : quo_n;
        rem_s  = neg_rem ? -rem_n : rem_n;
        res_hi = is_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
        res_lo = is_div ? quo_s : prod_s[WIDTH-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            Done     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && !Flush) begin
                        if (!Op[2]) begin
                            if (Op[1] && b_zero) begin
                                // Divide by zero completes at once
                                HI   <= A;
                                LO   <= '1;
                                Done <= 1'b1;
                            end else begin
                                state    <= RUN;
                                cnt      <= '0;
                                is_div   <= Op[1];
                                neg_main <= a_neg ^ b_neg;
                                neg_rem  <= Op[1] & a_neg;
                                acc_hi   <= '0;
                                // Multiply shifts the multiplier out of acc_lo;
                                // divide shifts the dividend out of it.
                                acc_lo   <= Op[1] ? a_mag : b_mag;
                                opnd     <= Op[1] ? b_mag : a_mag;
                            end
                        end else if (Op[1:0] == 2'b00) begin
                            HI   <= A;
                            Done <= 1'b1;
                        end else if (Op[1:0] == 2'b01) begin
                            LO   <= A;
                            Done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (Flush) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= iter_hi;
                        acc_lo <= iter_lo;
                        // The counter saturates at WIDTH and this check also
                        // catches any out-of-range count, so RUN always ends.
                        if (cnt >= LAST_CNT) begin
                            cnt   <= WIDTH_CNT;
                            state <= IDLE;
                            HI    <= res_hi;
                            LO    <= res_lo;
                            Done  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy      = (state == RUN);
    assign Stall     = Busy & (Start | HiLoRead);
    assign dbg_state = (state == RUN);

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit (WIDTH=32). A cycle-level reference model
// computes results with plain integer arithmetic. A negedge compare process
// checks every output against it on every cycle. Directed scenarios add
// hand-computed literal expectations.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         hilo_read;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbg_state;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .Op(op), .A(a), .B(b),
        .Flush(flush), .HiLoRead(hilo_read), .Busy(busy), .Done(done),
        .Stall(stall), .HI(hi), .LO(lo), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int           m_left = 0;      // iterative cycles still to run
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic         m_done = 1'b0;
    logic [W-1:0] p_hi   = '0;     // pending result of the running op
    logic [W-1:0] p_lo   = '0;

    function automatic void model_calc(input logic [2:0] mop, input logic [W-1:0] ma,
                                       input logic [W-1:0] mb,
                                       output logic [W-1:0] rhi, output logic [W-1:0] rlo);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sr;
        logic [63:0]        ur;
        sa = {{32{ma[W-1]}}, ma};
        sb = {{32{mb[W-1]}}, mb};
        rhi = '0;
        rlo = '0;
        case (mop)
            3'b000: begin sr = sa * sb; rhi = sr[63:32]; rlo = sr[31:0]; end
            3'b001: begin ur = {32'b0, ma} * {32'b0, mb}; rhi = ur[63:32]; rlo = ur[31:0]; end
            3'b010: begin
                sr = sa / sb; rlo = sr[31:0];
                sr = sa % sb; rhi = sr[31:0];
            end
            3'b011: begin rlo = ma / mb; rhi = ma % mb; end
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left != 0) begin
                if (flush) begin
                    m_left = 0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_hi   = p_hi;
                        m_lo   = p_lo;
                        m_done = 1'b1;
                    end
                end
            end else if (start && !flush) begin
                if (!op[2] && op[1] && b == '0) begin
                    m_hi   = a;
                    m_lo   = '1;
                    m_done = 1'b1;
                end else if (!op[2]) begin
                    model_calc(op, a, b, p_hi, p_lo);
                    m_left = W;
                end else if (op == 3'b100) begin
                    m_hi   = a;
                    m_done = 1'b1;
                end else if (op == 3'b101) begin
                    m_lo   = a;
                    m_done = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  64'(busy),  64'(m_left != 0));
            check("done",  64'(done),  64'(m_done));
            check("stall", 64'(stall), 64'((m_left != 0) && (start || hilo_read)));
            check("hi",    64'(hi),    64'(m_hi));
            check("lo",    64'(lo),    64'(m_lo));
            check("dbg_state", 64'(dbg_state), 64'(m_left != 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
    endtask

    // Waits for Done; returns negedges waited and Busy negedges seen.
    task automatic wait_done(output int lat, output int busy_cycles);
        bit ok;
        ok = 0;
        lat = 0;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                ok = 1;
                break;
            end
            if (busy) busy_cycles++;
        end
        check("done_seen", 64'(ok), 64'(1));
    endtask

    task automatic run_check(input string name, input logic [2:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] ehi,
                             input logic [W-1:0] elo, input int elat);
        int lat;
        int bc;
        start_op(o, x, y);
        wait_done(lat, bc);
        check({name, "_lat"}, 64'(lat), 64'(elat));
        check({name, "_busy"}, 64'(bc), 64'(elat - 1));
        check({name, "_hi"}, 64'(hi), 64'(ehi));
        check({name, "_lo"}, 64'(lo), 64'(elo));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] thi;
        logic [W-1:0] tlo;
        int lat;
        int bc;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        flush = 1'b0; hilo_read = 1'b0;

        // Pin the reference model on known answers
        model_calc(3'b000, 32'hFFFF_FFFF, 32'd2, thi, tlo);
        check("model_mult", {thi, tlo}, 64'hFFFF_FFFF_FFFF_FFFE);
        model_calc(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, thi, tlo);
        check("model_div_min", {thi, tlo}, 64'h0000_0000_8000_0000);
        model_calc(3'b010, 32'hFFFF_FFF9, 32'd2, thi, tlo);
        check("model_div_neg", {thi, tlo}, 64'hFFFF_FFFF_FFFF_FFFD);

        step();
        chk_en = 1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi",   64'(hi),   64'(0));
        check("rst_lo",   64'(lo),   64'(0));
        step();

        run_check("mult",  3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_check("multu", 3'b001, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 33);
        run_check("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_check("div_min", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_check("divu_zero", 3'b011, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1);
        run_check("div_7_m2", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        run_check("div_m7_m2", 3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 33);
        run_check("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_check("mult_mix", 3'b000, 32'h1234_5678, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hC962_FC98, 33);

        // Start/HiLoRead while busy: stall, second Start dropped
        step();
        start_op(3'b000, 32'd3, 32'hFFFF_FFFB);
        repeat (4) step();
        start = 1'b1; op = 3'b101; a = 32'hDEAD; hilo_read = 1'b1;
        @(negedge clk);
        check("stall_both", 64'(stall), 64'(1));
        step();
        start = 1'b0;
        @(negedge clk);
        check("stall_read", 64'(stall), 64'(1));
        step();
        hilo_read = 1'b0;
        wait_done(lat, bc);
        check("busy_mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("busy_mult_lo", 64'(lo), 64'hFFFF_FFF1);

        // MTHI, then DIVU in the Done cycle, flushed at cycle 10
        step();
        start_op(3'b100, 32'h1234, 32'd0);
        start_op(3'b011, 32'd100, 32'd7);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_done", 64'(done), 64'(0));
        check("flush_hi",   64'(hi),   64'h1234);
        repeat (3) step();

        // No-op codes and Flush-in-IDLE leave HI/LO alone
        start_op(3'b110, 32'h5555, 32'd1);
        start_op(3'b111, 32'h6666, 32'd1);
        flush = 1'b1;
        start_op(3'b100, 32'h9999, 32'd0);
        flush = 1'b0;
        @(negedge clk);
        check("noop_hi", 64'(hi), 64'h1234);
        step();

        // Reset at cycle 12 of MULT, then a fresh op
        start_op(3'b000, 32'd7, 32'd9);
        repeat (11) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_hi",   64'(hi),   64'(0));
        check("midrst_lo",   64'(lo),   64'(0));
        step();
        run_check("after_rst", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        // Reset overrides a simultaneous Start
        step();
        rst = 1'b1;
        start_op(3'b100, 32'hAAAA, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_start_hi", 64'(hi), 64'(0));
        step();
        start_op(3'b101, 32'h55, 32'd0);
        @(negedge clk);
        check("mtlo_lo", 64'(lo), 64'h55);
        step();
        step();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, HI and LO width (legal: 8..64, even).
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the iteration-counter width (must satisfy 2^CNT_W > WIDTH).
REQ-003 Clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Start  input  1  request to launch the operation given by Op.
REQ-006 Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-007 A  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
REQ-008 B  input  WIDTH  rt operand (multiplier / divisor).
REQ-009 Flush  input  1  abort any in-flight operation.
REQ-010 HiLoRead  input  1  the ID-stage instruction reads HI or LO (MFHI/MFLO/MADD class).
REQ-011 Busy  output  1  an iterative operation is in progress.
REQ-012 Done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 Stall  output  1  pipeline hold request.
REQ-014 HI  output  WIDTH  registered HI value.
REQ-015 LO  output  WIDTH  registered LO value.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-017 In IDLE, Start with Op MULT/MULTU/DIV/DIVU SHALL, at that edge, latch |A|, |B|, the result signs and the op, clear the counter, and enter RUN; this edge is E0.
REQ-018 Signed ops SHALL use magnitudes; unsigned ops SHALL use raw operands.
REQ-019 Each RUN cycle SHALL perform one iteration: shift-add for multiply, restoring subtract-shift for divide.
REQ-020 At edge E_WIDTH, WIDTH cycles after E0, the block SHALL write HI/LO, pulse Done for the following cycle, and return to IDLE.
REQ-021 Busy SHALL be 1 exactly in the cycles between E0 and E_WIDTH.
REQ-022 Multiply results SHALL be the 2*WIDTH product, with HI holding the upper half and LO the lower half; signed products SHALL be negated when the operand signs differ.
REQ-023 Divide results SHALL put the quotient in LO and the remainder in HI.
REQ-024 Signed divide: the quotient SHALL be negative iff the operand signs differ, and the remainder sign SHALL follow the dividend.
REQ-025 Signed divide of MIN by -1 SHALL give LO=MIN, HI=0.
REQ-026 Divide by zero SHALL skip RUN: at E0, HI=A and LO=all-ones, with Done in the next cycle and Busy never asserted.
REQ-027 MTHI/MTLO in IDLE SHALL write A to HI/LO at the Start edge, with Done in the next cycle and no RUN state.
REQ-028 Ops 110/111 SHALL change nothing and SHALL NOT pulse Done.
REQ-029 Start while Busy SHALL be ignored, with no relaunch and no HI/LO change.
REQ-030 Stall SHALL equal Busy AND (Start OR HiLoRead), combinationally.
REQ-031 Start is legal in the Done cycle and SHALL be accepted normally.
REQ-032 Flush in RUN SHALL return the FSM to IDLE at that edge, with HI/LO unchanged and no Done.
REQ-033 Flush has priority over Start in the same cycle; Flush in IDLE SHALL suppress any Start in that cycle.
REQ-034 The counter SHALL never wrap: it saturates at WIDTH, which forces the RUN->IDLE transition.
REQ-035 HI/LO SHALL change only at result write, MTHI/MTLO, or reset.

Reset
REQ-036 Rst at any edge, including mid-RUN, SHALL force IDLE, with Busy=0, Done=0, HI=0, LO=0 and the counter cleared.
REQ-037 Rst SHALL override Start and Flush in the same cycle.
REQ-038 After reset release, the first Start SHALL be accepted at the next edge.

Verification (WIDTH=32)
REQ-039 Bench SHALL cover MULT A=0xFFFFFFFF, B=2 -> Busy for 32 cycles, then Done with HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-040 Bench SHALL cover DIV A=-7, B=2 -> after 32 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
REQ-041 Bench SHALL cover DIVU A=7, B=0 -> Done one cycle after Start, HI=7, LO=0xFFFFFFFF, Busy stays 0.
REQ-042 Bench SHALL cover MULT in flight with Start and HiLoRead pulsed at cycle 5 -> Stall=1 in those cycles, second Start ignored, and the original result is unchanged.
REQ-043 Bench SHALL cover Flush at cycle 10 of DIVU after MTHI 0x1234 -> Busy=0 next cycle, no Done, HI=0x1234.
REQ-044 Bench SHALL cover Rst asserted at cycle 12 of MULT -> next cycle Busy=0, Done=0, HI=LO=0; a new Start is then accepted normally.
